// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: multi-cycle execution sequencer between the decoder and the 16-bit ALU/register file
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             instruction handshake; req_op/rdest/rsrc/use_imm/imm/imm_signed/shamt fields
//   rf_raddr_a/b, rf_rdata_a/b      register-file read ports (combinational read data)
//   rf_we/rf_waddr/rf_wdata         register-file write port
//   alu_rdest/alu_rsrc/alu_op       ALU operands and opcode, meaningful in EXEC only
//   alu_out/alu_flags               ALU result and flags {N,Z,F,L,C}
//   psr                             processor status register {N,Z,F,L,C}
//   busy/done/err                   in-flight flag, completion pulse, illegal-opcode pulse
module alu_exec_ctrl #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_op,
    input  logic [AW-1:0] req_rdest,
    input  logic [AW-1:0] req_rsrc,
    input  logic          req_use_imm,
    input  logic [7:0]    req_imm,
    input  logic          req_imm_signed,
    input  logic [3:0]    req_shamt,
    output logic [AW-1:0] rf_raddr_a,
    output logic [AW-1:0] rf_raddr_b,
    input  logic [DW-1:0] rf_rdata_a,
    input  logic [DW-1:0] rf_rdata_b,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [DW-1:0] alu_rdest,
    output logic [DW-1:0] alu_rsrc,
    output logic [4:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic [4:0]    alu_flags,
    output logic [4:0]    psr,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
    state_t state, state_nx;
    logic [4:0]    op;
    logic [AW-1:0] rdest, rsrc;
    logic          use_imm, imm_signed;
    logic [7:0]    imm;
    logic [3:0]    shamt, cnt;
    logic [DW-1:0] res, imm_ext;
    logic [4:0]    flg;
    logic          is_shift, is_legal;
    assign is_shift   = op inside {5'd7, 5'd8, 5'd9};
    assign is_legal   = op <= 5'd9;
    assign imm_ext    = imm_signed ? {{(DW-8){imm[7]}}, imm} : {{(DW-8){1'b0}}, imm};
    assign rf_raddr_a = rdest;
    assign rf_raddr_b = rsrc;
    assign rf_waddr   = rdest;
    assign rf_wdata   = res;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        rf_we     = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = FETCH;
            end
            FETCH: state_nx = EXEC;
            // shamt of 0 or 1 both leave after a single EXEC cycle
            EXEC: if (!is_shift || cnt <= 4'd1) state_nx = WB;
            WB: begin
                done     = 1'b1;
                err      = !is_legal;
                rf_we    = is_legal && op != 5'd2;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // alu_rsrc doubles as the shift accumulator, so the ALU operands hold outside EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= '0;
            rdest      <= '0;
            rsrc       <= '0;
            use_imm    <= 1'b0;
            imm        <= '0;
            imm_signed <= 1'b0;
            shamt      <= '0;
            cnt        <= '0;
            res        <= '0;
            flg        <= '0;
            alu_rdest  <= '0;
            alu_rsrc   <= '0;
            alu_op     <= '0;
            psr        <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op         <= req_op;
                    rdest      <= req_rdest;
                    rsrc       <= req_rsrc;
                    use_imm    <= req_use_imm;
                    imm        <= req_imm;
                    imm_signed <= req_imm_signed;
                    shamt      <= req_shamt;
                end
                FETCH: begin
                    alu_rdest <= rf_rdata_a;
                    alu_rsrc  <= use_imm ? imm_ext : rf_rdata_b;
                    alu_op    <= op;
                    cnt       <= shamt;
                end
                EXEC: if (is_shift) begin
                    if (cnt == 4'd0) res <= alu_rsrc;
                    else begin
                        alu_rsrc <= alu_out;
                        res      <= alu_out;
                        cnt      <= cnt - 4'd1;
                    end
                end else begin
                    res <= alu_out;
                    flg <= alu_flags;
                end
                WB: begin
                    if (op <= 5'd1) psr <= flg;
                    else if (op == 5'd2) psr <= {flg[4], flg[3], psr[2], flg[1], psr[0]};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: self-checking bench for alu_exec_ctrl with register-file and ALU models
module tb_alu_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [3:0]  req_rdest = '0, req_rsrc = '0;
    logic        req_use_imm = 1'b0;
    logic [7:0]  req_imm = '0;
    logic        req_imm_signed = 1'b0;
    logic [3:0]  req_shamt = '0;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_rdest, alu_rsrc, alu_out;
    logic [4:0]  alu_op, alu_flags, psr;
    logic        busy, done, err;
    logic [15:0] rf [16];
    logic [4:0]  psr_m = '0;
    int          tests = 0, fails = 0, we_cnt = 0;

    alu_exec_ctrl #(.DW(16), .AW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rdest(req_rdest), .req_rsrc(req_rsrc), .req_use_imm(req_use_imm),
        .req_imm(req_imm), .req_imm_signed(req_imm_signed), .req_shamt(req_shamt),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc), .alu_op(alu_op),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .psr(psr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // ALU: one-bit shifts, flags {N,Z,F,L,C}; SUB/CMP compute a-b with carry = no borrow
    function automatic logic [20:0] alu_f(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic [4:0]  f;
        s = '0;
        r = '0;
        f = '0;
        case (o)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                f = {1'b0, r == 16'h0, (a[15] == b[15]) && (r[15] != a[15]), 1'b0, s[16]};
            end
            5'd1, 5'd2: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r = s[15:0];
                f = {$signed(a) < $signed(b), a == b, (a[15] != b[15]) && (r[15] != a[15]), a < b, s[16]};
            end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            5'd6: r = ~b;
            5'd7: r = b << 1;
            5'd8: r = b >> 1;
            5'd9: r = $signed(b) >>> 1;
            default: r = 16'h0;
        endcase
        return {f, r};
    endfunction

    assign {alu_flags, alu_out} = alu_f(alu_op, alu_rdest, alu_rsrc);
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setr(input logic [3:0] i, input logic [15:0] v);
        rf[i] <= v;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs, input logic ui,
                         input logic [7:0] im, input logic is, input logic [3:0] sh);
        @(negedge clk);
        req_op = op;
        req_rdest = rd;
        req_rsrc = rs;
        req_use_imm = ui;
        req_imm = im;
        req_imm_signed = is;
        req_shamt = sh;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // scramble the request fields to show they were latched
        req_op = 5'($urandom);
        req_rdest = 4'($urandom);
        req_rsrc = 4'($urandom);
        req_use_imm = 1'($urandom);
        req_imm = 8'($urandom);
        req_imm_signed = 1'($urandom);
        req_shamt = 4'($urandom);
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic ui, input logic [7:0] im, input logic is, input logic [3:0] sh);
        logic [15:0] a, b, r;
        logic [4:0]  f, ep;
        logic        ewe;
        int          el, lat, w0;
        @(negedge clk);
        chk({tag, "_ready"}, req_ready, 1'b1);
        a = rf[rd];
        b = ui ? (is ? {{8{im[7]}}, im} : {8'h00, im}) : rf[rs];
        f = '0;
        el = 3;
        case (op)
            5'd7: r = b << sh;
            5'd8: r = b >> sh;
            5'd9: r = $signed(b) >>> sh;
            default: {f, r} = alu_f(op, a, b);
        endcase
        if (op >= 5'd7 && op <= 5'd9) el = 2 + (sh == 4'd0 ? 1 : int'(sh));
        ep  = op <= 5'd1 ? f : op == 5'd2 ? {f[4], f[3], psr_m[2], f[1], psr_m[0]} : psr_m;
        ewe = op <= 5'd9 && op != 5'd2;
        w0 = we_cnt;
        issue(op, rd, rs, ui, im, is, sh);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_err"}, err, op > 5'd9);
        chk({tag, "_we"}, rf_we, ewe);
        chk({tag, "_busy"}, busy, 1'b1);
        if (ewe) begin
            chk({tag, "_waddr"}, rf_waddr, rd);
            chk({tag, "_wdata"}, rf_wdata, r);
        end
        @(posedge clk);
        #1;
        chk({tag, "_psr"}, psr, ep);
        chk({tag, "_wecount"}, we_cnt - w0, ewe ? 1 : 0);
        chk({tag, "_idle"}, {busy, done, err}, 3'b000);
        if (ewe) chk({tag, "_rf"}, rf[rd], r);
        psr_m = ep;
    endtask

    initial begin
        int w0;
        logic [15:0] keep;
        for (int i = 0; i < 16; i++) setr(4'(i), 16'($urandom));
        #3;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_flags", {busy, done, err, rf_we}, 4'b0000);
        chk("rst_psr", psr, 5'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        setr(4'd1, 16'h7FFF);
        setr(4'd2, 16'h0001);
        run("add", 5'd0, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("tp_add_r1", rf[1], 16'h8000);
        chk("tp_add_psr", psr, 5'b00100);
        setr(4'd3, 16'h0005);
        setr(4'd4, 16'h0005);
        run("sub", 5'd1, 4'd3, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("tp_sub_r3", rf[3], 16'h0000);
        chk("tp_sub_psr", psr, 5'b01001);
        setr(4'd5, 16'h0003);
        setr(4'd6, 16'h0005);
        run("cmp", 5'd2, 4'd5, 4'd6, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("tp_cmp_psr", psr, 5'b10011);
        setr(4'd7, 16'h0001);
        run("lsh15", 5'd7, 4'd8, 4'd7, 1'b0, 8'h00, 1'b0, 4'd15);
        chk("tp_lsh_r8", rf[8], 16'h8000);
        run("rsh0", 5'd8, 4'd8, 4'd7, 1'b0, 8'h00, 1'b0, 4'd0);
        chk("tp_rsh0_r8", rf[8], 16'h0001);
        setr(4'd2, 16'h0010);
        run("addimm_s", 5'd0, 4'd2, 4'd9, 1'b1, 8'hFF, 1'b1, 4'd0);
        chk("tp_imms_r2", rf[2], 16'h000F);
        setr(4'd2, 16'h0010);
        run("addimm_u", 5'd0, 4'd2, 4'd9, 1'b1, 8'hFF, 1'b0, 4'd0);
        chk("tp_immu_r2", rf[2], 16'h010F);
        run("illegal", 5'd10, 4'd3, 4'd4, 1'b0, 8'h00, 1'b0, 4'd0);
        run("arsh", 5'd9, 4'd10, 4'd11, 1'b1, 8'h80, 1'b1, 4'd3);
        run("not", 5'd6, 4'd12, 4'd13, 1'b0, 8'h00, 1'b0, 4'd0);

        for (int k = 0; k < 30; k++)
            run("rand", 5'($urandom_range(0, 12)), 4'($urandom), 4'($urandom), 1'($urandom),
                8'($urandom), 1'($urandom), 4'($urandom));

        setr(4'd10, 16'h0003);
        run("pre_rst_sub", 5'd1, 4'd11, 4'd11, 1'b0, 8'h00, 1'b0, 4'd0);
        keep = rf[9];
        w0 = we_cnt;
        issue(5'd7, 4'd9, 4'd10, 1'b0, 8'h00, 1'b0, 4'd10);
        repeat (4) @(posedge clk);
        #2;
        chk("rst_mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_busy", busy, 1'b0);
        chk("rst_abort_ready", req_ready, 1'b1);
        chk("rst_abort_psr", psr, 5'b0);
        chk("rst_abort_we", rf_we, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        psr_m = '0;
        chk("rst_abort_wecount", we_cnt - w0, 0);
        chk("rst_abort_rf", rf[9], keep);
        run("post_rst_add", 5'd0, 4'd9, 4'd10, 1'b0, 8'h00, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
